// File: rtl/mem_port_arbiter_if.sv
// Request/grant, read-return and memory-command signals shared by the
// CPU/host memory arbiter and whatever sits on either side of it.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              i_cpuReq;
  logic              i_cpuWe;
  logic [ADDR_W-1:0] i_cpuAddr;
  logic [DATA_W-1:0] i_cpuWdata;
  logic              o_cpuGnt;
  logic              o_cpuRvalid;
  logic [DATA_W-1:0] o_cpuRdata;

  logic              i_hostReq;
  logic              i_hostWe;
  logic [ADDR_W-1:0] i_hostAddr;
  logic [DATA_W-1:0] i_hostWdata;
  logic              i_hostLock;
  logic              o_hostGnt;
  logic              o_hostRvalid;
  logic [DATA_W-1:0] o_hostRdata;

  logic [ADDR_W-1:0] o_memAddr;
  logic [DATA_W-1:0] o_memData;
  logic              o_memWrEnable;
  logic [DATA_W-1:0] i_memData;

  modport slave (
    input  i_cpuReq, i_cpuWe, i_cpuAddr, i_cpuWdata,
    output o_cpuGnt, o_cpuRvalid, o_cpuRdata,
    input  i_hostReq, i_hostWe, i_hostAddr, i_hostWdata, i_hostLock,
    output o_hostGnt, o_hostRvalid, o_hostRdata,
    output o_memAddr, o_memData, o_memWrEnable,
    input  i_memData
  );

  modport master (
    output i_cpuReq, i_cpuWe, i_cpuAddr, i_cpuWdata,
    input  o_cpuGnt, o_cpuRvalid, o_cpuRdata,
    output i_hostReq, i_hostWe, i_hostAddr, i_hostWdata, i_hostLock,
    input  o_hostGnt, o_hostRvalid, o_hostRdata,
    input  o_memAddr, o_memData, o_memWrEnable,
    output i_memData
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin CPU/host arbiter for the single-port data memory, with registered
// memory commands and owner-tagged read return. Define ARB_LOCK_EN for host lock.
module mem_port_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int LOCK_MAX = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  mem_port_arbiter_if.slave   bus
);

  logic              last_host_q, last_host_d;
  logic              cpu_gnt, host_gnt;
  logic              lock_hold, lock_expired;

  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              mem_we_q, mem_we_d;

  logic              rd_vld_p1_q, rd_vld_p1_d;
  logic              rd_own_p1_q, rd_own_p1_d;
  logic              rd_vld_p2_q;
  logic              rd_own_p2_q;
  logic              cpu_rvalid, host_rvalid;

`ifdef ARB_LOCK_EN
  localparam logic [7:0] LOCK_CMP = 8'(LOCK_MAX);
  logic [7:0] lock_cnt_q, lock_cnt_d;

  // Host keeps the port while locked until LOCK_MAX grants have starved the CPU.
  always_comb begin
    lock_expired = bus.i_cpuReq && (lock_cnt_q == LOCK_CMP);
    lock_hold    = bus.i_hostLock && bus.i_hostReq && !lock_expired;
  end

  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (cpu_gnt || !bus.i_cpuReq || !bus.i_hostLock) begin
      lock_cnt_d = '0;
    end else if (host_gnt) begin
      lock_cnt_d = lock_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lock_cnt_q <= '0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
    end
  end
`else
  logic unused_host_lock;
  assign unused_host_lock = bus.i_hostLock;
  assign lock_hold        = 1'b0;
  assign lock_expired     = 1'b0;
`endif

  always_comb begin
    cpu_gnt  = 1'b0;
    host_gnt = 1'b0;
    if (bus.i_cpuReq && bus.i_hostReq) begin
      if (lock_expired) begin
        cpu_gnt = 1'b1;
      end else if (lock_hold) begin
        host_gnt = 1'b1;
      end else if (last_host_q) begin
        cpu_gnt = 1'b1;
      end else begin
        host_gnt = 1'b1;
      end
    end else if (bus.i_cpuReq) begin
      cpu_gnt = 1'b1;
    end else if (bus.i_hostReq) begin
      host_gnt = 1'b1;
    end
  end

  assign bus.o_cpuGnt  = cpu_gnt;
  assign bus.o_hostGnt = host_gnt;

  always_comb begin
    last_host_d = last_host_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    mem_we_d    = 1'b0;
    rd_vld_p1_d = 1'b0;
    rd_own_p1_d = 1'b0;
    if (cpu_gnt) begin
      last_host_d = 1'b0;
      mem_addr_d  = bus.i_cpuAddr;
      mem_data_d  = bus.i_cpuWdata;
      mem_we_d    = bus.i_cpuWe;
      rd_vld_p1_d = !bus.i_cpuWe;
      rd_own_p1_d = 1'b0;
    end else if (host_gnt) begin
      last_host_d = 1'b1;
      mem_addr_d  = bus.i_hostAddr;
      mem_data_d  = bus.i_hostWdata;
      mem_we_d    = bus.i_hostWe;
      rd_vld_p1_d = !bus.i_hostWe;
      rd_own_p1_d = 1'b1;
    end
  end

  // Stage 1: command to memory plus read tag; stage 2: tag aligned with memory data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_host_q <= 1'b1;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_we_q    <= 1'b0;
      rd_vld_p1_q <= 1'b0;
      rd_own_p1_q <= 1'b0;
      rd_vld_p2_q <= 1'b0;
      rd_own_p2_q <= 1'b0;
    end else begin
      last_host_q <= last_host_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      mem_we_q    <= mem_we_d;
      rd_vld_p1_q <= rd_vld_p1_d;
      rd_own_p1_q <= rd_own_p1_d;
      rd_vld_p2_q <= rd_vld_p1_q;
      rd_own_p2_q <= rd_own_p1_q;
    end
  end

  assign bus.o_memAddr     = mem_addr_q;
  assign bus.o_memData     = mem_data_q;
  assign bus.o_memWrEnable = mem_we_q;

  assign cpu_rvalid  = rd_vld_p2_q && !rd_own_p2_q;
  assign host_rvalid = rd_vld_p2_q &&  rd_own_p2_q;

  assign bus.o_cpuRvalid  = cpu_rvalid;
  assign bus.o_hostRvalid = host_rvalid;
  assign bus.o_cpuRdata   = cpu_rvalid  ? bus.i_memData : '0;
  assign bus.o_hostRdata  = host_rvalid ? bus.i_memData : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic, checked
// every cycle against a transaction-level model with its own memory image.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int ADDR_W      = 16;
  localparam int DATA_W      = 16;
  localparam int LOCK_MAX_TB = 3;
  localparam int MEM_N       = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ram_load = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_MAX(LOCK_MAX_TB)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  // Synchronous-read memory attached to the arbiter's memory port.
  logic [DATA_W-1:0] ram [MEM_N];
  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < MEM_N; i++) ram[i] <= 16'(16'hA0 + i);
    end else begin
      if (bus.o_memWrEnable) ram[bus.o_memAddr[5:0]] <= bus.o_memData;
      bus.i_memData <= ram[bus.o_memAddr[5:0]];
    end
  end

  typedef struct {
    bit          host;
    logic [15:0] data;
    int          due;
  } rd_t;

  logic [15:0] model_mem [MEM_N];
  rd_t         rq[$];
  bit          m_last_host;
  bit          m_we;
  logic [15:0] m_addr, m_data;
  int          m_lock;
  int          cyc;
  int          tests, fails;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_last_host = 1'b1;
    m_we = 1'b0;
    m_addr = '0;
    m_data = '0;
    m_lock = 0;
    rq.delete();
  endtask

  task automatic drive(input bit cr, input bit cw, input logic [15:0] ca, input logic [15:0] cd,
                       input bit hr, input bit hw, input logic [15:0] ha, input logic [15:0] hd,
                       input bit hl);
    bus.i_cpuReq = cr;  bus.i_cpuWe = cw;  bus.i_cpuAddr = ca;  bus.i_cpuWdata = cd;
    bus.i_hostReq = hr; bus.i_hostWe = hw; bus.i_hostAddr = ha; bus.i_hostWdata = hd;
    bus.i_hostLock = hl;
  endtask

  // One clock cycle: apply inputs, then compare every output with the model.
  task automatic step(input bit cr, input bit cw, input logic [15:0] ca, input logic [15:0] cd,
                      input bit hr, input bit hw, input logic [15:0] ha, input logic [15:0] hd,
                      input bit hl);
    bit eg_c, eg_h, ev_c, ev_h;
    logic [15:0] ed;
    rd_t r;
    @(posedge clk); #1;
    drive(cr, cw, ca, cd, hr, hw, ha, hd, hl);
    @(negedge clk);
    cyc++;

    eg_c = 1'b0; eg_h = 1'b0;
    if (cr && hr) begin
`ifdef ARB_LOCK_EN
      if (hl && m_lock >= LOCK_MAX_TB) eg_c = 1'b1;
      else if (hl)                     eg_h = 1'b1;
      else if (m_last_host)            eg_c = 1'b1;
      else                             eg_h = 1'b1;
`else
      if (m_last_host) eg_c = 1'b1;
      else             eg_h = 1'b1;
`endif
    end else if (cr) begin
      eg_c = 1'b1;
    end else if (hr) begin
      eg_h = 1'b1;
    end
    chk("cpu_gnt",  32'(bus.o_cpuGnt),  32'(eg_c));
    chk("host_gnt", 32'(bus.o_hostGnt), 32'(eg_h));

    chk("mem_we",   32'(bus.o_memWrEnable), 32'(m_we));
    chk("mem_addr", 32'(bus.o_memAddr),     32'(m_addr));
    chk("mem_data", 32'(bus.o_memData),     32'(m_data));

    ev_c = 1'b0; ev_h = 1'b0; ed = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      r = rq.pop_front();
      ed = r.data;
      if (r.host) ev_h = 1'b1; else ev_c = 1'b1;
    end
    chk("cpu_rvalid",  32'(bus.o_cpuRvalid),  32'(ev_c));
    chk("cpu_rdata",   32'(bus.o_cpuRdata),   32'(ev_c ? ed : 16'h0));
    chk("host_rvalid", 32'(bus.o_hostRvalid), 32'(ev_h));
    chk("host_rdata",  32'(bus.o_hostRdata),  32'(ev_h ? ed : 16'h0));

    m_we = 1'b0;
    if (eg_c) begin
      m_last_host = 1'b0;
      m_we = cw; m_addr = ca; m_data = cd;
      if (cw) model_mem[ca[5:0]] = cd;
      else    rq.push_back('{host: 1'b0, data: model_mem[ca[5:0]], due: cyc + 2});
    end else if (eg_h) begin
      m_last_host = 1'b1;
      m_we = hw; m_addr = ha; m_data = hd;
      if (hw) model_mem[ha[5:0]] = hd;
      else    rq.push_back('{host: 1'b1, data: model_mem[ha[5:0]], due: cyc + 2});
    end
    if (eg_c || !cr || !hl) m_lock = 0;
    else if (eg_h)          m_lock++;
  endtask

  task automatic idle();
    step(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_mem_addr"},    32'(bus.o_memAddr),     32'h0);
    chk({tag, "_mem_data"},    32'(bus.o_memData),     32'h0);
    chk({tag, "_mem_we"},      32'(bus.o_memWrEnable), 32'h0);
    chk({tag, "_cpu_rvalid"},  32'(bus.o_cpuRvalid),   32'h0);
    chk({tag, "_host_rvalid"}, 32'(bus.o_hostRvalid),  32'h0);
    chk({tag, "_cpu_rdata"},   32'(bus.o_cpuRdata),    32'h0);
    chk({tag, "_host_rdata"},  32'(bus.o_hostRdata),   32'h0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0);
    #2;
    check_reset_values("mid_rst");
    @(posedge clk); #1;
    chk("mid_rst_we_held", 32'(bus.o_memWrEnable), 32'h0);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wcount;
    tests = 0; fails = 0; cyc = 0;
    for (int i = 0; i < MEM_N; i++) model_mem[i] = 16'(16'hA0 + i);
    model_reset();
    drive(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0);
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("por");
    rst_n = 1'b1;
    ram_load = 1'b0;

    // Host write then read-back of address 5.
    step(0, 0, 16'h0, 16'h0, 1, 1, 16'h0005, 16'h1234, 0);
    chk("t1_host_gnt_wr", 32'(bus.o_hostGnt), 32'h1);
    step(0, 0, 16'h0, 16'h0, 1, 0, 16'h0005, 16'h0, 0);
    chk("t1_we_pulse", 32'(bus.o_memWrEnable), 32'h1);
    chk("t1_we_addr",  32'(bus.o_memAddr),     32'h5);
    chk("t1_we_data",  32'(bus.o_memData),     32'h1234);
    idle();
    chk("t1_rvalid_early", 32'(bus.o_hostRvalid), 32'h0);
    idle();
    chk("t1_host_rvalid", 32'(bus.o_hostRvalid), 32'h1);
    chk("t1_host_rdata",  32'(bus.o_hostRdata),  32'h1234);
    chk("t1_cpu_rvalid",  32'(bus.o_cpuRvalid),  32'h0);
    idle();

    // Both requesters reading continuously: grants alternate starting with CPU.
    for (int k = 0; k < 6; k++) begin
      step(1, 0, 16'(10 + k), 16'h0, 1, 0, 16'(20 + k), 16'h0, 0);
      chk("t2_cpu_gnt",  32'(bus.o_cpuGnt),  32'((k % 2) == 0));
      chk("t2_host_gnt", 32'(bus.o_hostGnt), 32'((k % 2) == 1));
    end
    idle(); idle();

    // Four back-to-back CPU reads of the preloaded words.
    for (int k = 0; k < 6; k++) begin
      if (k < 4) step(1, 0, 16'(k), 16'h0, 0, 0, 16'h0, 16'h0, 0);
      else       idle();
      if (k >= 2) begin
        chk("t3_cpu_rvalid", 32'(bus.o_cpuRvalid), 32'h1);
        chk("t3_cpu_rdata",  32'(bus.o_cpuRdata),  32'(16'hA0 + k - 2));
      end
    end
    idle();

    // Single CPU write, request dropped after grant.
    step(1, 1, 16'h0014, 16'hBEEF, 0, 0, 16'h0, 16'h0, 0);
    wcount = 0;
    for (int k = 0; k < 4; k++) begin
      idle();
      if (bus.o_memWrEnable) wcount++;
    end
    chk("t6_write_count", 32'(wcount), 32'h1);

    // Reset pulsed the cycle after a host read grant.
    step(0, 0, 16'h0, 16'h0, 1, 0, 16'h0007, 16'h0, 0);
    chk("t4_host_gnt", 32'(bus.o_hostGnt), 32'h1);
    pulse_reset();
    idle();
    chk("t4_no_cpu_rvalid",  32'(bus.o_cpuRvalid),  32'h0);
    chk("t4_no_host_rvalid", 32'(bus.o_hostRvalid), 32'h0);
    step(1, 0, 16'h0001, 16'h0, 1, 0, 16'h0002, 16'h0, 0);
    chk("t4_first_gnt_cpu", 32'(bus.o_cpuGnt), 32'h1);
    idle(); idle(); idle();

`ifdef ARB_LOCK_EN
    // Host lock holds the port for LOCK_MAX grants, then CPU gets one.
    for (int k = 0; k < 8; k++) begin
      step(1, 0, 16'h0003, 16'h0, 1, 0, 16'h0004, 16'h0, 1);
      chk("lock_cpu_gnt",  32'(bus.o_cpuGnt),  32'((k % 4) == 3));
      chk("lock_host_gnt", 32'(bus.o_hostGnt), 32'((k % 4) != 3));
    end
    idle(); idle(); idle();
`endif

    // Random mixed traffic.
    for (int n = 0; n < 3000; n++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           16'($urandom_range(0, MEM_N - 1)), 16'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           16'($urandom_range(0, MEM_N - 1)), 16'($urandom),
           1'($urandom_range(0, 1)));
    end
    idle(); idle(); idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
